// File: rtl/sfifo_asym_prog_if.sv
// sfifo_asym_prog_if
//   Bundles the producer/consumer side of sfifo_asym_prog: write request and
//   data, read request and data, the two runtime watermarks and all status and
//   error flags. clock0/Flush stay outside as plain ports.
//   master : the user side (drives PUSH/DIN/POP/UPAF/UPAE, observes the rest)
//   slave  : the FIFO side
interface sfifo_asym_prog_if #(
  parameter int DATA_WIDTH0 = 36,
  parameter int DATA_WIDTH1 = 18,
  parameter int ADDR_WIDTH0 = 9
);
  localparam int G           = (DATA_WIDTH0 < DATA_WIDTH1) ? DATA_WIDTH0 : DATA_WIDTH1;
  localparam int ADDR_WIDTH1 = ADDR_WIDTH0 + $clog2(DATA_WIDTH0 / G) - $clog2(DATA_WIDTH1 / G);

  logic                   PUSH;
  logic [DATA_WIDTH0-1:0] DIN;
  logic                   POP;
  logic [DATA_WIDTH1-1:0] DOUT;
  logic [ADDR_WIDTH0-1:0] UPAF;
  logic [ADDR_WIDTH1-1:0] UPAE;
  logic                   Full;
  logic                   Almost_Full;
  logic                   Empty;
  logic                   Almost_Empty;
  logic                   Full_Watermark;
  logic                   Empty_Watermark;
  logic                   Overrun_Error;
  logic                   Underrun_Error;

  modport master (
    output PUSH, DIN, POP, UPAF, UPAE,
    input  DOUT, Full, Almost_Full, Empty, Almost_Empty,
           Full_Watermark, Empty_Watermark, Overrun_Error, Underrun_Error
  );

  modport slave (
    input  PUSH, DIN, POP, UPAF, UPAE,
    output DOUT, Full, Almost_Full, Empty, Almost_Empty,
           Full_Watermark, Empty_Watermark, Overrun_Error, Underrun_Error
  );
endinterface

// File: rtl/sfifo_asym_prog.sv
// sfifo_asym_prog
//   Single-clock FIFO with asymmetric write/read widths (power-of-2 ratio up to
//   4), optional first-word-fall-through output, runtime watermarks and sticky
//   overrun/underrun flags. Storage is split into NL granule-wide lanes, each an
//   inferred RAM with a registered read, so a wide word is one row across lanes.
//   Ports:
//     clock0 : rising-edge clock
//     Flush  : synchronous active-high flush, clears all state and DOUT
//     bus    : sfifo_asym_prog_if.slave (PUSH/DIN, POP/DOUT, UPAF/UPAE, flags)
module sfifo_asym_prog #(
  parameter int DATA_WIDTH0 = 36,
  parameter int DATA_WIDTH1 = 18,
  parameter int ADDR_WIDTH0 = 9,
  parameter int FWFT        = 0
) (
  input logic              clock0,
  input logic              Flush,
  sfifo_asym_prog_if.slave bus
);
  localparam int G      = (DATA_WIDTH0 < DATA_WIDTH1) ? DATA_WIDTH0 : DATA_WIDTH1;
  localparam int WG     = DATA_WIDTH0 / G;
  localparam int RG     = DATA_WIDTH1 / G;
  localparam int NL     = (WG > RG) ? WG : RG;
  localparam int LOG_WG = $clog2(WG);
  localparam int LOG_RG = $clog2(RG);
  localparam int LOG_NL = $clog2(NL);
  localparam int GAW    = ADDR_WIDTH0 + LOG_WG;  // granule pointer width
  localparam int LAW    = GAW - LOG_NL;          // per-lane row address width
  localparam int CW     = ADDR_WIDTH0 + 3;
  localparam int D      = 1 << GAW;

  localparam logic [CW-1:0] D_C  = CW'(D);
  localparam logic [CW-1:0] WG_C = CW'(WG);
  localparam logic [CW-1:0] RG_C = CW'(RG);

  logic [GAW-1:0]         wptr_reg, rptr_reg, rptr_q_reg;
  logic [CW-1:0]          cnt_reg, cnt_next, ram_cnt_reg, ram_cnt_next;
  logic                   a_vld_reg, a_vld_next, b_vld_reg, b_vld_next;
  logic [DATA_WIDTH1-1:0] dout_b_reg, rd_word;
  logic [NL*G-1:0]        row_q;
  logic                   push_ok, pop_ok, fetch, a_to_b, rd_en;
  int                     wbase, rbase;

  logic full_reg, afull_reg, empty_reg, aempty_reg, fwm_reg, ewm_reg, ovr_reg, und_reg;
  logic full_next, afull_next, empty_next, aempty_next, fwm_next, ewm_next;

  always_comb begin
    push_ok = bus.PUSH && !full_reg;
    pop_ok  = bus.POP && !empty_reg;
    // FWFT: stage A is the lane read register, stage B is dout_b_reg. A refills
    // from RAM in the same edge it hands its word to B, so pops never bubble.
    if (FWFT != 0) begin
      a_to_b = a_vld_reg && (!b_vld_reg || pop_ok);
      fetch  = (ram_cnt_reg >= RG_C) && (!a_vld_reg || a_to_b);
      rd_en  = fetch;
    end else begin
      a_to_b = 1'b0;
      fetch  = 1'b0;
      rd_en  = pop_ok;
    end

    cnt_next     = cnt_reg + (push_ok ? WG_C : '0) - (pop_ok ? RG_C : '0);
    ram_cnt_next = ram_cnt_reg + (push_ok ? WG_C : '0) - (fetch ? RG_C : '0);
    a_vld_next   = fetch ? 1'b1 : (a_to_b ? 1'b0 : a_vld_reg);
    b_vld_next   = a_to_b ? 1'b1 : (pop_ok ? 1'b0 : b_vld_reg);

    full_next  = (D_C - cnt_next) < WG_C;
    afull_next = (D_C - cnt_next) == WG_C;
    fwm_next   = (cnt_next >> LOG_WG) >= CW'(bus.UPAF);
    ewm_next   = (cnt_next >> LOG_RG) <= CW'(bus.UPAE);
    if (FWFT != 0) begin
      empty_next  = !b_vld_next;
      aempty_next = b_vld_next && (cnt_next == RG_C);
    end else begin
      empty_next  = cnt_next < RG_C;
      aempty_next = cnt_next == RG_C;
    end

    // Lane offset of the write/read pointer inside its row; both pointers stay
    // aligned to their word size, so a word occupies consecutive lanes.
    wbase   = int'(wptr_reg) % NL;
    rbase   = int'(rptr_q_reg) % NL;
    rd_word = row_q[rbase*G +: DATA_WIDTH1];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_lane
      logic [G-1:0] mem [0:(1<<LAW)-1];
      logic [G-1:0] q_reg;
      logic         we;

      assign we = push_ok && !Flush && ((gi / WG) == (wbase / WG));

      always_ff @(posedge clock0) begin
        if (we) mem[wptr_reg[GAW-1:LOG_NL]] <= bus.DIN[(gi % WG)*G +: G];
      end

      always_ff @(posedge clock0) begin
        if (Flush)      q_reg <= '0;
        else if (rd_en) q_reg <= mem[rptr_reg[GAW-1:LOG_NL]];
      end

      assign row_q[gi*G +: G] = q_reg;
    end
  endgenerate

  always_ff @(posedge clock0) begin
    if (Flush) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      rptr_q_reg  <= '0;
      cnt_reg     <= '0;
      ram_cnt_reg <= '0;
      a_vld_reg   <= 1'b0;
      b_vld_reg   <= 1'b0;
      dout_b_reg  <= '0;
      full_reg    <= 1'b0;
      afull_reg   <= 1'b0;
      empty_reg   <= 1'b1;
      aempty_reg  <= 1'b0;
      fwm_reg     <= 1'b0;
      ewm_reg     <= 1'b1;
      ovr_reg     <= 1'b0;
      und_reg     <= 1'b0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + GAW'(WG);
      if (rd_en) begin
        rptr_reg   <= rptr_reg + GAW'(RG);
        rptr_q_reg <= rptr_reg;
      end
      if (a_to_b) dout_b_reg <= rd_word;
      cnt_reg     <= cnt_next;
      ram_cnt_reg <= ram_cnt_next;
      a_vld_reg   <= a_vld_next;
      b_vld_reg   <= b_vld_next;
      full_reg    <= full_next;
      afull_reg   <= afull_next;
      empty_reg   <= empty_next;
      aempty_reg  <= aempty_next;
      fwm_reg     <= fwm_next;
      ewm_reg     <= ewm_next;
      if (bus.PUSH && full_reg) ovr_reg <= 1'b1;
      if (bus.POP && empty_reg) und_reg <= 1'b1;
    end
  end

  assign bus.DOUT            = (FWFT != 0) ? dout_b_reg : rd_word;
  assign bus.Full            = full_reg;
  assign bus.Almost_Full     = afull_reg;
  assign bus.Empty           = empty_reg;
  assign bus.Almost_Empty    = aempty_reg;
  assign bus.Full_Watermark  = fwm_reg;
  assign bus.Empty_Watermark = ewm_reg;
  assign bus.Overrun_Error   = ovr_reg;
  assign bus.Underrun_Error  = und_reg;
endmodule

// File: tb/tb_sfifo_asym_prog.sv
// tb_sfifo_asym_prog
//   Directed bench for sfifo_asym_prog (36-bit write, 18-bit read, 512 write
//   words). u_std runs with registered read, u_fwft with first-word-fall-through.
module tb_sfifo_asym_prog;
  logic clk = 1'b0;
  logic flush0, flush1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sfifo_asym_prog_if #(.DATA_WIDTH0(36), .DATA_WIDTH1(18), .ADDR_WIDTH0(9)) bus0 ();
  sfifo_asym_prog_if #(.DATA_WIDTH0(36), .DATA_WIDTH1(18), .ADDR_WIDTH0(9)) bus1 ();

  sfifo_asym_prog #(.DATA_WIDTH0(36), .DATA_WIDTH1(18), .ADDR_WIDTH0(9), .FWFT(0)) u_std (
    .clock0(clk), .Flush(flush0), .bus(bus0)
  );
  sfifo_asym_prog #(.DATA_WIDTH0(36), .DATA_WIDTH1(18), .ADDR_WIDTH0(9), .FWFT(1)) u_fwft (
    .clock0(clk), .Flush(flush1), .bus(bus1)
  );

  typedef struct {
    logic        flush, push, pop;
    logic [35:0] din;
    logic        e_empty, e_aempty, e_full, e_ewm, e_ovr, e_und;
    logic [17:0] e_dout;
  } vec_t;

  vec_t vt [11];

  function automatic logic [35:0] pat(int a);
    return 36'(a) | (36'(a) << 20) | 36'h55000;
  endfunction

  function automatic logic [17:0] gran(int k);
    logic [35:0] w;
    w = pat(k / 2);
    return (k % 2 != 0) ? w[35:18] : w[17:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    flush0 = 1'b0; flush1 = 1'b0;
    bus0.PUSH = 1'b0; bus0.POP = 1'b0; bus0.DIN = '0; bus0.UPAF = 9'd256; bus0.UPAE = 10'd4;
    bus1.PUSH = 1'b0; bus1.POP = 1'b0; bus1.DIN = '0; bus1.UPAF = 9'd256; bus1.UPAE = 10'd4;

    // flush, push, pop, din, empty, aempty, full, ewm, ovr, und, dout
    vt[0]  = '{1'b1, 1'b0, 1'b0, 36'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 36'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 36'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 36'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 18'h0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 36'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 36'h123456789, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 36'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 18'h16789};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 36'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h048D1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 36'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h048D1};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 36'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 18'h048D1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 36'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0};

    // Flush, single-word push, two pops, underrun and hold behaviour.
    for (int i = 0; i < 11; i++) begin
      flush0 = vt[i].flush; bus0.PUSH = vt[i].push; bus0.POP = vt[i].pop; bus0.DIN = vt[i].din;
      step();
      $display("vec %0d: flush=%0b push=%0b pop=%0b dout=%h empty=%0b und=%0b",
               i, vt[i].flush, vt[i].push, vt[i].pop, bus0.DOUT, bus0.Empty, bus0.Underrun_Error);
      chk($sformatf("vec%0d empty", i),  bus0.Empty,           vt[i].e_empty);
      chk($sformatf("vec%0d aempty", i), bus0.Almost_Empty,    vt[i].e_aempty);
      chk($sformatf("vec%0d full", i),   bus0.Full,            vt[i].e_full);
      chk($sformatf("vec%0d ewm", i),    bus0.Empty_Watermark, vt[i].e_ewm);
      chk($sformatf("vec%0d ovr", i),    bus0.Overrun_Error,   vt[i].e_ovr);
      chk($sformatf("vec%0d und", i),    bus0.Underrun_Error,  vt[i].e_und);
      chk($sformatf("vec%0d dout", i),   bus0.DOUT,            vt[i].e_dout);
    end
    flush0 = 1'b0; bus0.PUSH = 1'b0; bus0.POP = 1'b0;

    // Fill to capacity with watermark checks, overrun, then drain in order.
    flush0 = 1'b1; step(); flush0 = 1'b0;
    for (int a = 0; a < 512; a++) begin
      bus0.PUSH = 1'b1; bus0.DIN = pat(a);
      step();
      if (a == 1)   chk("ewm at 4 granules", bus0.Empty_Watermark, 1'b1);
      if (a == 2)   chk("ewm at 6 granules", bus0.Empty_Watermark, 1'b0);
      if (a == 254) chk("fwm after 255 pushes", bus0.Full_Watermark, 1'b0);
      if (a == 255) chk("fwm after 256 pushes", bus0.Full_Watermark, 1'b1);
      if (a == 510) begin
        chk("afull after 511", bus0.Almost_Full, 1'b1);
        chk("full after 511", bus0.Full, 1'b0);
      end
      if (a == 511) begin
        chk("afull after 512", bus0.Almost_Full, 1'b0);
        chk("full after 512", bus0.Full, 1'b1);
        chk("ovr after 512", bus0.Overrun_Error, 1'b0);
      end
    end
    $display("fill: 512 words pushed, full=%0b", bus0.Full);
    bus0.DIN = 36'hFFFFFFFFF;
    step();
    chk("ovr after 513th push", bus0.Overrun_Error, 1'b1);
    chk("full after 513th push", bus0.Full, 1'b1);
    bus0.PUSH = 1'b0; bus0.POP = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      step();
      chk($sformatf("drain dout %0d", k), bus0.DOUT, gran(k));
    end
    bus0.POP = 1'b0;
    $display("drain: 1024 words popped, empty=%0b", bus0.Empty);
    chk("empty after drain", bus0.Empty, 1'b1);
    chk("und after drain", bus0.Underrun_Error, 1'b0);
    chk("ovr sticky after drain", bus0.Overrun_Error, 1'b1);

    // FWFT: single word, latency to Empty fall, back-to-back delivery, underrun.
    flush1 = 1'b1; step(); flush1 = 1'b0;
    chk("fwft flush empty", bus1.Empty, 1'b1);
    chk("fwft flush dout", bus1.DOUT, 18'h0);
    chk("fwft flush und", bus1.Underrun_Error, 1'b0);
    bus1.PUSH = 1'b1; bus1.DIN = 36'h123456789;
    step(); bus1.PUSH = 1'b0;
    chk("fwft empty edge0", bus1.Empty, 1'b1);
    step();
    chk("fwft empty edge1", bus1.Empty, 1'b1);
    step();
    chk("fwft empty edge2", bus1.Empty, 1'b0);
    chk("fwft dout edge2", bus1.DOUT, 18'h16789);
    bus1.POP = 1'b1;
    step();
    chk("fwft dout pop1", bus1.DOUT, 18'h048D1);
    chk("fwft empty pop1", bus1.Empty, 1'b0);
    chk("fwft aempty pop1", bus1.Almost_Empty, 1'b1);
    step();
    chk("fwft empty pop2", bus1.Empty, 1'b1);
    chk("fwft und pop2", bus1.Underrun_Error, 1'b0);
    step();
    chk("fwft und pop3", bus1.Underrun_Error, 1'b1);
    bus1.POP = 1'b0;
    $display("fwft single word: und=%0b", bus1.Underrun_Error);

    flush1 = 1'b1; step(); flush1 = 1'b0;
    for (int a = 0; a < 3; a++) begin
      bus1.PUSH = 1'b1; bus1.DIN = pat(a);
      step();
    end
    bus1.PUSH = 1'b0;
    step(); step();
    chk("fwft stream head", bus1.DOUT, gran(0));
    bus1.POP = 1'b1;
    for (int k = 1; k < 6; k++) begin
      step();
      chk($sformatf("fwft stream dout %0d", k), bus1.DOUT, gran(k));
      chk($sformatf("fwft stream empty %0d", k), bus1.Empty, 1'b0);
    end
    step();
    chk("fwft stream empty end", bus1.Empty, 1'b1);
    bus1.POP = 1'b0;
    $display("fwft stream: 6 granules popped back-to-back");

    // Half fill, 100 cycles of simultaneous push/pop, then flush mid-stream.
    bus0.UPAF = 9'd306;
    flush0 = 1'b1; step(); flush0 = 1'b0;
    for (int a = 0; a < 256; a++) begin
      bus0.PUSH = 1'b1; bus0.DIN = pat(a);
      step();
    end
    chk("fwm half fill", bus0.Full_Watermark, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      bus0.PUSH = 1'b1; bus0.POP = 1'b1; bus0.DIN = pat(255 + k);
      step();
      chk($sformatf("stream dout %0d", k), bus0.DOUT, gran(k - 1));
      if (k == 99)  chk("fwm at 611 granules", bus0.Full_Watermark, 1'b0);
      if (k == 100) chk("fwm at 612 granules", bus0.Full_Watermark, 1'b1);
    end
    $display("stream: 100 push+pop cycles, fwm=%0b", bus0.Full_Watermark);
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    chk("midflush empty", bus0.Empty, 1'b1);
    chk("midflush dout", bus0.DOUT, 18'h0);
    chk("midflush und", bus0.Underrun_Error, 1'b0);
    chk("midflush ovr", bus0.Overrun_Error, 1'b0);
    chk("midflush fwm", bus0.Full_Watermark, 1'b0);
    bus0.PUSH = 1'b1; bus0.POP = 1'b0; bus0.DIN = 36'h123456789;
    step();
    chk("postflush empty", bus0.Empty, 1'b0);
    bus0.PUSH = 1'b0; bus0.POP = 1'b1;
    step();
    chk("postflush dout lo", bus0.DOUT, 18'h16789);
    step();
    chk("postflush dout hi", bus0.DOUT, 18'h048D1);
    chk("postflush empty end", bus0.Empty, 1'b1);
    bus0.POP = 1'b0;
    $display("postflush: push/pop sequence done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
